instr_fetch: RTL

//  Fetch stage directly downstream of the program counter. Reads programCounter, requests the

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/instr_fetch_if.sv | 27 ++
 rtl/fetch_skid.sv | 58 +++++
 rtl/instr_fetch.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Optional feature macro: FETCH_TIMEOUT_EN (ack watchdog in instr_fetch).
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 10;
    localparam int unsigned FETCH_DATA_W = 32;

    // Request FSM: IDLE waits for a slot, REQ holds the memory request until ack.
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch bus: instruction-memory req/ack channel plus the valid/ready channel to decode.
// master = fetch stage view, slave = memory/decode environment view.
interface instr_fetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = FETCH_ADDR_W,
    parameter int unsigned DATA_W = FETCH_DATA_W
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [DATA_W-1:0] instruction;
    logic [ADDR_W-1:0] fetch_pc;

    modport master (
        output imem_req, imem_addr, fetch_valid, instruction, fetch_pc,
        input  imem_ack, imem_rdata, fetch_ready
    );

    modport slave (
        input  imem_req, imem_addr, fetch_valid, instruction, fetch_pc,
        output imem_ack, imem_rdata, fetch_ready
    );
endinterface

// File: rtl/fetch_skid.sv
// Output register plus one-entry skid buffer for the fetch -> decode channel.
// Ports: clk, rst_n (async active-low), clear (drop everything held),
//        in_valid/in_data (captured word), out_valid/out_data/out_ready (to decode),
//        skid_full (second slot occupied; upstream must not issue another request).
module fetch_skid
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clear,
    input  logic   in_valid,
    input  entry_t in_data,
    input  logic   out_ready,
    output logic   out_valid,
    output entry_t out_data,
    output logic   skid_full
);

    entry_t skid_data;
    logic   skid_valid;
    logic   consume;

    assign consume   = out_valid & out_ready;
    assign skid_full = skid_valid;

    // Output refills from the skid first so words leave in arrival order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (clear) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || consume) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= in_valid;
                if (in_valid) begin
                    skid_data <= in_data;
                end
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_data <= in_data;
                end
            end
        end else if (in_valid) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: samples programCounter, requests the word from instruction
// memory over req/ack, and hands {pc, word} to decode through fetch_skid.
// Ports: clock, resetCPU (async active-low), programCounter, HLT (no new requests),
//        flush (redirect pulse), pc_hold (combinational: 0 only in the cycle a word is
//        captured), fetch_err (watchdog, sticky), bus (instr_fetch_if.master).
// Optional: define FETCH_TIMEOUT_EN to enable the TMO_CYC ack watchdog; otherwise
//        fetch_err is tied 0 and REQ waits indefinitely.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = FETCH_ADDR_W,
    parameter int unsigned DATA_W = FETCH_DATA_W
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TMO_CYC = 64
`endif
) (
    input  logic              clock,
    input  logic              resetCPU,
    input  logic [ADDR_W-1:0] programCounter,
    input  logic              HLT,
    input  logic              flush,
    output logic              pc_hold,
    output logic              fetch_err,
    instr_fetch_if.master     bus
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] word;
    } entry_t;

    fetch_state_t      state;
    fetch_state_t      state_d;
    logic              req_d;
    logic [ADDR_W-1:0] addr_d;
    logic              drop;
    logic              drop_d;
    logic              skid_full;
    logic              capture;
    logic              tmo;
    logic              err_stop;
    entry_t            cap_entry;
    entry_t            out_entry;

    // A word is kept only if it was not flushed earlier (drop) or in this very cycle.
    assign capture   = (state == REQ) & bus.imem_ack & ~drop & ~flush;
    assign cap_entry = '{pc: bus.imem_addr, word: bus.imem_rdata};

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TMO_CYC + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             err;

    // tmo_cnt holds the number of ack-less REQ cycles already elapsed.
    assign tmo       = (state == REQ) && !bus.imem_ack && (tmo_cnt == CNT_W'(TMO_CYC - 1));
    assign err_stop  = err;
    assign fetch_err = err;

    always_ff @(posedge clock or negedge resetCPU) begin
        if (!resetCPU) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state != REQ || bus.imem_ack) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (tmo) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign tmo       = 1'b0;
    assign err_stop  = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // State and registered request outputs.
    always_ff @(posedge clock or negedge resetCPU) begin
        if (!resetCPU) begin
            state         <= IDLE;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= '0;
            drop          <= 1'b0;
        end else begin
            state         <= state_d;
            bus.imem_req  <= req_d;
            bus.imem_addr <= addr_d;
            drop          <= drop_d;
        end
    end

    // Next state: one outstanding request at most, none while halted, flushing or backed up.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (!HLT && !flush && !skid_full && !err_stop) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.imem_ack || tmo) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: request address, drop flag and PC hold.
    always_comb begin
        req_d   = 1'b0;
        addr_d  = bus.imem_addr;
        drop_d  = drop;
        pc_hold = 1'b1;
        if (state == IDLE && state_d == REQ) begin
            addr_d = programCounter;
        end
        req_d = (state_d == REQ);
        // A flush cannot abort the request; remember to discard its word instead.
        if (state_d == IDLE) begin
            drop_d = 1'b0;
        end else if (state == REQ && flush) begin
            drop_d = 1'b1;
        end
        if (capture) begin
            pc_hold = 1'b0;
        end
    end

    fetch_skid #(
        .entry_t (entry_t)
    ) u_skid (
        .clk       (clock),
        .rst_n     (resetCPU),
        .clear     (flush),
        .in_valid  (capture),
        .in_data   (cap_entry),
        .out_ready (bus.fetch_ready),
        .out_valid (bus.fetch_valid),
        .out_data  (out_entry),
        .skid_full (skid_full)
    );

    assign bus.instruction = out_entry.word;
    assign bus.fetch_pc    = out_entry.pc;

endmodule
